// File: rtl/uart_tx_pkg.sv
// UART transmitter shared definitions.
// State encodings and parameter defaults for uart_tx.
package uart_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_START = 2'b01,
    ST_DATA  = 2'b10,
    ST_STOP  = 2'b11
  } tx_state_e;

  localparam int NB_DATA_DEF = 8;
  localparam int SB_TICK_DEF = 16;
  localparam int DVSR_DEF    = 326;
  localparam int OS_LAST     = 15;

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// FIFO-side handshake of the UART transmitter.
// Member names follow the transmitter's point of view.
interface uart_tx_if
  import uart_tx_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF
);

  logic               i_fifo_empty;
  logic [NB_DATA-1:0] i_fifo_data;
  logic               o_fifo_read;

  modport master (
    output i_fifo_empty,
    output i_fifo_data,
    input  o_fifo_read
  );

  modport slave (
    input  i_fifo_empty,
    input  i_fifo_data,
    output o_fifo_read
  );

endinterface

// File: rtl/uart_tx_baud_rate_gen.sv
// Mod-DVSR oversample tick generator.
// Clear holds the count at zero so every frame starts phase-aligned.
module baud_rate_gen
  import uart_tx_pkg::*;
#(
  parameter int DVSR = DVSR_DEF
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  output logic o_tick
);

  localparam int CW = cnt_w(DVSR);

  logic [CW-1:0] r_cnt;

  assign o_tick = (r_cnt == CW'(DVSR - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear || o_tick)
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: pops words from a FIFO and sends 8N1 frames,
// LSB first, with bit timing from an oversample tick generator.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int SB_TICK = SB_TICK_DEF,
  parameter int DVSR    = DVSR_DEF
) (
  input  logic i_clk,
  input  logic i_reset,
  uart_tx_if.slave fifo,
  output logic o_tx,
  output logic o_tx_busy,
  output logic o_tx_done
);

  localparam int SW = (cnt_w(SB_TICK) > 4) ? cnt_w(SB_TICK) : 4;
  localparam int NW = cnt_w(NB_DATA);

  tx_state_e          r_state, w_state_n;
  logic [SW-1:0]      r_s, w_s_n;
  logic [NW-1:0]      r_n, w_n_n;
  logic [NB_DATA-1:0] r_b, w_b_n;
  logic               r_tx, w_tx_n;
  logic               r_done, w_done_n;
  logic               w_tick;
  logic               w_idle;
  logic               w_read;

  assign w_idle = (r_state == ST_IDLE);
  // Reset gates the pop so a held reset never drains the FIFO.
  assign w_read = w_idle && !fifo.i_fifo_empty && !i_reset;

  assign fifo.o_fifo_read = w_read;
  assign o_tx             = r_tx;
  assign o_tx_busy        = !w_idle;
  assign o_tx_done        = r_done;

  baud_rate_gen #(
    .DVSR (DVSR)
  ) u_baud (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (w_idle),
    .o_tick  (w_tick)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_b     <= '0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_s     <= w_s_n;
      r_n     <= w_n_n;
      r_b     <= w_b_n;
      r_tx    <= w_tx_n;
      r_done  <= w_done_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_s_n     = r_s;
    w_n_n     = r_n;
    w_b_n     = r_b;
    w_done_n  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_read) begin
          w_b_n     = fifo.i_fifo_data;
          w_s_n     = '0;
          w_n_n     = '0;
          w_state_n = ST_START;
        end
      end
      ST_START: begin
        if (w_tick) begin
          if (r_s == SW'(OS_LAST)) begin
            w_s_n     = '0;
            w_n_n     = '0;
            w_state_n = ST_DATA;
          end else begin
            w_s_n = r_s + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          if (r_s == SW'(OS_LAST)) begin
            w_s_n = '0;
            w_b_n = r_b >> 1;
            if (r_n == NW'(NB_DATA - 1))
              w_state_n = ST_STOP;
            else
              w_n_n = r_n + 1'b1;
          end else begin
            w_s_n = r_s + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          if (r_s == SW'(SB_TICK - 1)) begin
            w_s_n     = '0;
            w_done_n  = 1'b1;
            w_state_n = ST_IDLE;
          end else begin
            w_s_n = r_s + 1'b1;
          end
        end
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  // Line level follows the state being entered, so o_tx stays registered.
  always_comb begin
    w_tx_n = 1'b1;
    unique case (w_state_n)
      ST_START: w_tx_n = 1'b0;
      ST_DATA:  w_tx_n = w_b_n[0];
      default:  w_tx_n = 1'b1;
    endcase
  end

endmodule
